piso_shift_tx: RTL

Parallel-in/serial-out shift transmitter: accepts a WIDTH-bit word over a valid/ready handshake and drives it out one bit per clock on a framed serial line. It is the transmit end of the team's 1-bit shift-register chain: parallel words go in, and a bit stream comes out for a chain of D flip-flops or a serial-to-parallel receiver. Back-to-back words stream with no idle gap.

---
 rtl/piso_shift_tx.sv | 105 ++++++++++
 1 files changed

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out shift transmitter: takes a WIDTH-bit word over valid/ready
// and drives it out one bit per clock with framing, streaming back-to-back words gaplessly.
module piso_shift_tx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sdata,
    output logic             sframe,
    output logic             slast,
    output logic             busy
);

    localparam int unsigned     CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] sreg_shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             sdata_q, sdata_d;
    logic             sframe_q, sframe_d;
    logic             slast_q, slast_d;
    logic             at_last;
    logic             accept;

    // The bit at the output end is already on sdata when sreg is loaded, so it never feeds logic.
    logic             sreg_out_end_unused;
    assign sreg_out_end_unused = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
            sdata_q  <= 1'b0;
            sframe_q <= 1'b0;
            slast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            sdata_q  <= sdata_d;
            sframe_q <= sframe_d;
            slast_q  <= slast_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (at_last && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        at_last    = (cnt_q == CNT_LAST);
        load_ready = (state_q == IDLE) || ((state_q == SHIFT) && at_last);
        accept     = load_valid && load_ready;
        busy       = (state_q == SHIFT);
        sdata      = sdata_q;
        sframe     = sframe_q;
        slast      = slast_q;
    end

    always_comb begin
        sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
        cnt_inc      = cnt_q + CNT_W'(1);
        sreg_d       = sreg_q;
        cnt_d        = cnt_q;
        sdata_d      = sdata_q;
        sframe_d     = sframe_q;
        slast_d      = slast_q;
        if (accept) begin
            sreg_d   = load_data;
            sdata_d  = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
            cnt_d    = '0;
            sframe_d = 1'b1;
            slast_d  = 1'b0;
        end else if (state_q == SHIFT && !at_last) begin
            sreg_d   = sreg_shifted;
            sdata_d  = MSB_FIRST ? sreg_shifted[WIDTH-1] : sreg_shifted[0];
            cnt_d    = cnt_inc;
            sframe_d = 1'b1;
            slast_d  = (cnt_inc == CNT_LAST);
        end else if (state_q == SHIFT) begin
            sdata_d  = 1'b0;
            sframe_d = 1'b0;
            slast_d  = 1'b0;
        end
    end

endmodule
